// File: rtl/vm2002_common_pkg.sv
// Shared vm2002 types: coin denominations, coin values and dispenser FSM states.
package vm2002_common_pkg;

  typedef enum logic [1:0] {
    NONE    = 2'd0,
    NICKEL  = 2'd1,
    DIME    = 2'd2,
    QUARTER = 2'd3
  } coins_t;

  localparam int unsigned NICKEL_VAL  = 5;
  localparam int unsigned DIME_VAL    = 10;
  localparam int unsigned QUARTER_VAL = 25;

  typedef enum logic [1:0] {
    IDLE,
    SELECT,
    DISPENSE,
    DONE
  } disp_state_t;

  function automatic int unsigned coin_value(coins_t c);
    case (c)
      NICKEL:  return NICKEL_VAL;
      DIME:    return DIME_VAL;
      QUARTER: return QUARTER_VAL;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/vm2002_coin_select.sv
// Combinational greedy chooser: largest coin that fits the remaining amount and is in stock.
module vm2002_coin_select
  import vm2002_common_pkg::*;
#(
  parameter int unsigned AMT_W = 8,
  parameter int unsigned INV_W = 8
) (
  input  logic [AMT_W-1:0] remaining,
  input  logic [INV_W-1:0] inv_nickel,
  input  logic [INV_W-1:0] inv_dime,
  input  logic [INV_W-1:0] inv_quarter,
  output coins_t           coin,
  output logic             found
);

  always_comb begin
    coin  = NONE;
    found = 1'b0;
    if (remaining >= AMT_W'(QUARTER_VAL) && inv_quarter != '0) begin
      coin  = QUARTER;
      found = 1'b1;
    end else if (remaining >= AMT_W'(DIME_VAL) && inv_dime != '0) begin
      coin  = DIME;
      found = 1'b1;
    end else if (remaining >= AMT_W'(NICKEL_VAL) && inv_nickel != '0) begin
      coin  = NICKEL;
      found = 1'b1;
    end
  end

endmodule

// File: rtl/vm2002_change_dispenser.sv
// vm2002 change-return engine: pays change one coin at a time via a hopper handshake.
// Optional ack-timeout watchdog enabled by defining VM2002_CHANGE_TIMEOUT_EN.
module vm2002_change_dispenser
  import vm2002_common_pkg::*;
#(
  parameter int unsigned AMT_W       = 8,
  parameter int unsigned INV_W       = 8,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             hrst,
  input  logic             change_valid,
  input  logic [AMT_W-1:0] change_amount,
  output logic             change_ready,
  input  logic             load_valid,
  input  coins_t           load_coin,
  input  logic [INV_W-1:0] load_count,
  output logic             dispense_req,
  output coins_t           dispense_coin,
  input  logic             dispense_ack,
  output logic             change_done,
  output logic             change_short,
  output logic [AMT_W-1:0] change_left,
  output logic             hopper_fault,
  output logic [INV_W-1:0] inv_nickel,
  output logic [INV_W-1:0] inv_dime,
  output logic [INV_W-1:0] inv_quarter
);

  disp_state_t      state, state_nx;
  logic [AMT_W-1:0] remaining;
  coins_t           cur_coin;
  coins_t           sel_coin;
  logic             sel_found;
  logic             timeout;

  function automatic logic [INV_W-1:0] sat_add(logic [INV_W-1:0] a, logic [INV_W-1:0] b);
    logic [INV_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[INV_W] ? '1 : s[INV_W-1:0];
  endfunction

  vm2002_coin_select #(
    .AMT_W (AMT_W),
    .INV_W (INV_W)
  ) u_select (
    .remaining   (remaining),
    .inv_nickel  (inv_nickel),
    .inv_dime    (inv_dime),
    .inv_quarter (inv_quarter),
    .coin        (sel_coin),
    .found       (sel_found)
  );

  always_ff @(posedge clk or posedge hrst) begin
    if (hrst) state <= IDLE;
    else      state <= state_nx;
  end

  // Outputs decode straight from the state register so hrst drops req without a clock.
  always_comb begin
    state_nx      = state;
    change_ready  = (state == IDLE);
    dispense_req  = (state == DISPENSE);
    dispense_coin = (state == DISPENSE) ? cur_coin : NONE;
    change_done   = (state == DONE);
    case (state)
      IDLE:     if (change_valid) state_nx = SELECT;
      SELECT:   state_nx = sel_found ? DISPENSE : DONE;
      DISPENSE: begin
        if (dispense_ack) state_nx = SELECT;
        else if (timeout) state_nx = DONE;
      end
      DONE:     state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge hrst) begin
    if (hrst) begin
      remaining    <= '0;
      cur_coin     <= NONE;
      inv_nickel   <= '0;
      inv_dime     <= '0;
      inv_quarter  <= '0;
      change_short <= 1'b0;
      change_left  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (change_valid) begin
            remaining    <= change_amount;
            change_short <= 1'b0;
            change_left  <= '0;
          end
          if (load_valid) begin
            case (load_coin)
              NICKEL:  inv_nickel  <= sat_add(inv_nickel, load_count);
              DIME:    inv_dime    <= sat_add(inv_dime, load_count);
              QUARTER: inv_quarter <= sat_add(inv_quarter, load_count);
              default: ;
            endcase
          end
        end
        SELECT: begin
          if (sel_found) begin
            cur_coin <= sel_coin;
          end else begin
            change_short <= (remaining != '0);
            change_left  <= remaining;
          end
        end
        DISPENSE: begin
          if (dispense_ack) begin
            remaining <= remaining - AMT_W'(coin_value(cur_coin));
            case (cur_coin)
              NICKEL:  inv_nickel  <= inv_nickel - 1'b1;
              DIME:    inv_dime    <= inv_dime - 1'b1;
              QUARTER: inv_quarter <= inv_quarter - 1'b1;
              default: ;
            endcase
          end else if (timeout) begin
            change_short <= 1'b1;
            change_left  <= remaining;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef VM2002_CHANGE_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(ACK_TIMEOUT + 1);

  logic [TO_W-1:0] to_cnt;
  logic            fault_q;

  // Counter is zero on the first DISPENSE cycle, so req stays up for exactly ACK_TIMEOUT cycles.
  assign timeout = (state == DISPENSE) && !dispense_ack && (to_cnt == TO_W'(ACK_TIMEOUT - 1));

  always_ff @(posedge clk or posedge hrst) begin
    if (hrst) begin
      to_cnt  <= '0;
      fault_q <= 1'b0;
    end else if (state == DISPENSE && !dispense_ack) begin
      to_cnt <= to_cnt + 1'b1;
      if (timeout) fault_q <= 1'b1;
    end else begin
      to_cnt <= '0;
    end
  end

  assign hopper_fault = fault_q;
`else
  assign timeout      = 1'b0;
  assign hopper_fault = 1'b0;
`endif

endmodule

// File: tb/tb_vm2002_change_dispenser.sv
// Scoreboard bench for vm2002_change_dispenser: directed requests, hopper model, monitor checks.
module tb_vm2002_change_dispenser;
  import vm2002_common_pkg::*;

  localparam int AMT_W = 8;
  localparam int INV_W = 8;

  logic             clk;
  logic             hrst;
  logic             change_valid;
  logic [AMT_W-1:0] change_amount;
  logic             change_ready;
  logic             load_valid;
  coins_t           load_coin;
  logic [INV_W-1:0] load_count;
  logic             dispense_req;
  coins_t           dispense_coin;
  logic             dispense_ack;
  logic             change_done;
  logic             change_short;
  logic [AMT_W-1:0] change_left;
  logic             hopper_fault;
  logic [INV_W-1:0] inv_nickel;
  logic [INV_W-1:0] inv_dime;
  logic [INV_W-1:0] inv_quarter;

  vm2002_change_dispenser #(
    .AMT_W       (AMT_W),
    .INV_W       (INV_W),
    .ACK_TIMEOUT (16)
  ) dut (
    .clk           (clk),
    .hrst          (hrst),
    .change_valid  (change_valid),
    .change_amount (change_amount),
    .change_ready  (change_ready),
    .load_valid    (load_valid),
    .load_coin     (load_coin),
    .load_count    (load_count),
    .dispense_req  (dispense_req),
    .dispense_coin (dispense_coin),
    .dispense_ack  (dispense_ack),
    .change_done   (change_done),
    .change_short  (change_short),
    .change_left   (change_left),
    .hopper_fault  (hopper_fault),
    .inv_nickel    (inv_nickel),
    .inv_dime      (inv_dime),
    .inv_quarter   (inv_quarter)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit     is_done;
    coins_t coin;
    bit     shrt;
    int     left;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   ack_delay = 0;
  bit   hopper_en = 1'b1;
  int   req_cycles = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Hopper: acks ack_delay cycles after req is first seen; req stays high ack_delay+1 cycles.
  initial begin
    int cnt;
    cnt = 0;
    dispense_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (hrst || !hopper_en || !dispense_req || dispense_ack) begin
        dispense_ack = 1'b0;
        cnt = 0;
      end else if (cnt >= ack_delay) begin
        dispense_ack = 1'b1;
      end else begin
        cnt++;
      end
    end
  end

  // Monitor: pops the scoreboard on each new coin request and on each completion pulse.
  initial begin
    bit     prev_req;
    coins_t prev_coin;
    exp_t   e;
    prev_req  = 1'b0;
    prev_coin = NONE;
    forever begin
      @(negedge clk);
      if (hrst) begin
        prev_req = 1'b0;
        continue;
      end
      if (dispense_req) begin
        req_cycles++;
        if (prev_req) begin
          chk("coin_stable", int'(dispense_coin), int'(prev_coin));
        end else if (sb.size() == 0) begin
          chk("pending_for_req", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          chk("kind_coin", int'(e.is_done), 0);
          chk("coin", int'(dispense_coin), int'(e.coin));
        end
      end
      if (change_done) begin
        if (sb.size() == 0) begin
          chk("pending_for_done", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          chk("kind_done", int'(e.is_done), 1);
          chk("short", int'(change_short), int'(e.shrt));
          chk("left", int'(change_left), e.left);
        end
      end
      prev_req  = dispense_req;
      prev_coin = dispense_coin;
    end
  end

  task automatic push_coin(input coins_t c);
    exp_t e;
    e.is_done = 1'b0; e.coin = c; e.shrt = 1'b0; e.left = 0;
    sb.push_back(e);
  endtask

  task automatic push_done(input bit s, input int l);
    exp_t e;
    e.is_done = 1'b1; e.coin = NONE; e.shrt = s; e.left = l;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    hrst = 1'b1;
    repeat (2) @(negedge clk);
    hrst = 1'b0;
    sb.delete();
  endtask

  task automatic load(input coins_t c, input int n);
    @(negedge clk);
    load_valid = 1'b1;
    load_coin  = c;
    load_count = INV_W'(n);
    @(negedge clk);
    load_valid = 1'b0;
    load_coin  = NONE;
    load_count = '0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(sb.size() == 0 && change_ready) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("idle_within_budget", (n < 400) ? 1 : 0, 1);
  endtask

  task automatic run_change(input int amt);
    @(negedge clk);
    change_valid  = 1'b1;
    change_amount = AMT_W'(amt);
    @(negedge clk);
    change_valid  = 1'b0;
    wait_idle();
  endtask

  task automatic check_inv(input int q, input int d, input int n);
    chk("inv_quarter", int'(inv_quarter), q);
    chk("inv_dime", int'(inv_dime), d);
    chk("inv_nickel", int'(inv_nickel), n);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int rc0;
    int n;
    hrst          = 1'b1;
    change_valid  = 1'b0;
    change_amount = '0;
    load_valid    = 1'b0;
    load_coin     = NONE;
    load_count    = '0;
    do_reset();
    @(negedge clk);

    // Reset state
    chk("rst_ready", int'(change_ready), 1);
    chk("rst_req", int'(dispense_req), 0);
    chk("rst_coin", int'(dispense_coin), int'(NONE));
    chk("rst_done", int'(change_done), 0);
    chk("rst_short", int'(change_short), 0);
    chk("rst_left", int'(change_left), 0);
    chk("rst_fault", int'(hopper_fault), 0);
    check_inv(0, 0, 0);

    // 40c from a full stock: one of each coin
    load(QUARTER, 4); load(DIME, 4); load(NICKEL, 4);
    check_inv(4, 4, 4);
    push_coin(QUARTER); push_coin(DIME); push_coin(NICKEL); push_done(1'b0, 0);
    run_change(40);
    check_inv(3, 3, 3);

    // 30c with no quarters
    do_reset();
    load(DIME, 2); load(NICKEL, 5);
    push_coin(DIME); push_coin(DIME); push_coin(NICKEL); push_coin(NICKEL); push_done(1'b0, 0);
    run_change(30);
    check_inv(0, 0, 3);

    // Short change: stock runs out, then a non-multiple-of-5 amount
    do_reset();
    load(DIME, 1);
    push_coin(DIME); push_done(1'b1, 5);
    run_change(15);
    check_inv(0, 0, 0);
    load(NICKEL, 1);
    push_coin(NICKEL); push_done(1'b1, 2);
    run_change(7);
    check_inv(0, 0, 0);

    // Zero change with a concurrent load; done must appear in cycle N+2
    rc0 = req_cycles;
    push_done(1'b0, 0);
    @(negedge clk);
    change_valid  = 1'b1;
    change_amount = '0;
    load_valid    = 1'b1;
    load_coin     = NICKEL;
    load_count    = INV_W'(3);
    @(negedge clk);
    change_valid = 1'b0;
    load_valid   = 1'b0;
    load_coin    = NONE;
    chk("zero_n1_ready", int'(change_ready), 0);
    chk("zero_n1_done", int'(change_done), 0);
    @(negedge clk);
    chk("zero_n2_done", int'(change_done), 1);
    chk("zero_n2_short", int'(change_short), 0);
    @(negedge clk);
    chk("zero_n3_ready", int'(change_ready), 1);
    chk("zero_no_req", req_cycles - rc0, 0);
    check_inv(0, 0, 3);

    // Inventory saturates at the counter maximum
    load(NICKEL, 255);
    chk("sat_nickel", int'(inv_nickel), 255);

    // Slow hopper: req held for the whole wait, one decrement
    load(QUARTER, 2);
    ack_delay = 5;
    rc0 = req_cycles;
    push_coin(QUARTER); push_done(1'b0, 0);
    run_change(25);
    chk("slow_req_cycles", req_cycles - rc0, 6);
    check_inv(1, 0, 255);
    ack_delay = 0;

    // hrst in the middle of DISPENSE
    hopper_en = 1'b0;
    push_coin(NICKEL);
    @(negedge clk);
    change_valid  = 1'b1;
    change_amount = AMT_W'(10);
    @(negedge clk);
    change_valid = 1'b0;
    n = 0;
    while (!dispense_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_seen_before_rst", int'(dispense_req), 1);
    #2;
    hrst = 1'b1;
    #1;
    chk("async_req_low", int'(dispense_req), 0);
    chk("async_coin_none", int'(dispense_coin), int'(NONE));
    chk("async_ready", int'(change_ready), 1);
    check_inv(0, 0, 0);
    @(negedge clk);
    hrst = 1'b0;
    sb.delete();
    hopper_en = 1'b1;
    @(negedge clk);
`ifndef VM2002_CHANGE_TIMEOUT_EN
    chk("fault_tied_low", int'(hopper_fault), 0);
`else
    // Hopper never answers: watchdog aborts with full amount unpaid
    load(DIME, 1);
    hopper_en = 1'b0;
    rc0 = req_cycles;
    push_coin(DIME); push_done(1'b1, 10);
    run_change(10);
    chk("to_req_cycles", req_cycles - rc0, 16);
    chk("to_fault", int'(hopper_fault), 1);
    check_inv(0, 1, 0);
    hopper_en = 1'b1;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
